// File: rtl/game_flow_ctrl_if.sv
// rtl/game_flow_ctrl_if.sv - round controller signal bundle (buttons, timer feedback, orders, status)
interface game_flow_ctrl_if #(
    parameter int SCORE_W = 10
);
    logic               start_btn;
    logic               pause_btn;
    logic [7:0]         time_left;
    logic               order_done;
    logic [3:0]         order_points;
    logic               timer_go;
    logic               restart;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;
    logic               low_time;
    logic               game_over;

    modport master (
        output start_btn, pause_btn, time_left, order_done, order_points,
        input  timer_go, restart, game_state, score, low_time, game_over
    );

    modport slave (
        input  start_btn, pause_btn, time_left, order_done, order_points,
        output timer_go, restart, game_state, score, low_time, game_over
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - round sequencer driving the countdown timer, with saturating score
// Optional pause support compiled in with GAME_PAUSE_EN.
module game_flow_ctrl #(
    parameter int                 SCORE_W   = 10,
    parameter logic [SCORE_W-1:0] MAX_SCORE = 10'd999,
    parameter logic [7:0]         WARN_TIME = 8'd10
) (
    input  logic            clock,
    input  logic            rst_n,
    game_flow_ctrl_if.slave io
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [SCORE_W-1:0] score_q;
    logic               game_over_q;
    logic [SCORE_W:0]   score_sum;
    logic               in_round;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (io.start_btn) state_nx = PLAYING;
            end
            PLAYING: begin
                // Expiry wins over a simultaneous pause request.
                if (io.time_left == 8'd0) begin
                    state_nx = OVER;
                end
`ifdef GAME_PAUSE_EN
                else if (io.pause_btn) begin
                    state_nx = PAUSED;
                end
`endif
            end
            PAUSED: begin
`ifdef GAME_PAUSE_EN
                if (io.pause_btn) state_nx = PLAYING;
`else
                state_nx = IDLE;
`endif
            end
            OVER: begin
                if (io.start_btn) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifndef GAME_PAUSE_EN
    logic unused_pause;
    assign unused_pause = io.pause_btn;
`endif

    // Sum one bit wider so the saturation compare cannot wrap.
    assign score_sum = {1'b0, score_q} + {{(SCORE_W-3){1'b0}}, io.order_points};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            score_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            game_over_q <= (state_nx == OVER) && (state != OVER);
            if (state == IDLE && io.start_btn) begin
                score_q <= '0;
            end else if (state == PLAYING && io.order_done) begin
                if (score_sum > {1'b0, MAX_SCORE}) begin
                    score_q <= MAX_SCORE;
                end else begin
                    score_q <= score_sum[SCORE_W-1:0];
                end
            end
        end
    end

`ifdef GAME_PAUSE_EN
    assign in_round = (state == PLAYING) || (state == PAUSED);
`else
    assign in_round = (state == PLAYING);
`endif

    assign io.timer_go   = (state == PLAYING);
    assign io.restart    = (state == IDLE);
    assign io.game_state = state;
    assign io.score      = score_q;
    assign io.game_over  = game_over_q;
    assign io.low_time   = in_round && (io.time_left != 8'd0) && (io.time_left <= WARN_TIME);
endmodule
